// File: rtl/dm_resp_pkg.sv
// dm_resp_pkg: shared definitions for the data-memory responder.
//   state_t     - responder FSM states (IDLE / WAIT / RESP)
//   BE_*        - lane-enable patterns (big-endian: be[0] is bits 0:7)
//   CNT_W       - wait-state counter width (WAIT_CYCLES legal range 0..15)
//   be_legal()  - lane-enable vs. byte-offset legality, used only when
//                 DM_ALIGN_CHK_EN is defined
package dm_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [0:3] BE_WORD    = 4'b1111;
  localparam logic [0:3] BE_HALF_HI = 4'b1100;
  localparam logic [0:3] BE_HALF_LO = 4'b0011;

  localparam int unsigned CNT_W = 4;

  // Legal: full word or upper half at offset 0, lower half at offset 2,
  // a single lane at its own offset, or no lanes at any offset.
  function automatic logic be_legal(input logic [0:3] be, input logic [1:0] laddr);
    logic ok;
    ok = 1'b0;
    case (be)
      BE_WORD:    ok = (laddr == 2'd0);
      BE_HALF_HI: ok = (laddr == 2'd0);
      BE_HALF_LO: ok = (laddr == 2'd2);
      4'b1000:    ok = (laddr == 2'd0);
      4'b0100:    ok = (laddr == 2'd1);
      4'b0010:    ok = (laddr == 2'd2);
      4'b0001:    ok = (laddr == 2'd3);
      4'b0000:    ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_resp_ram.sv
// dm_resp_ram: word-organised data array built from four byte-wide banks.
//   clk      rising-edge clock
//   i_re     read enable; o_rdata updates at the next edge and then holds
//   i_raddr  read word index
//   i_we     write enable, qualified per lane by i_be
//   i_waddr  write word index
//   i_be     lane enables, i_be[i] covers bits 8i:8i+7 (bit 0 = MSB)
//   i_wdata  lane-aligned write word
//   o_rdata  registered read word
// Contents are not reset.
module dm_resp_ram #(
  parameter int unsigned DEPTH = 10
) (
  input  logic             clk,
  input  logic             i_re,
  input  logic [DEPTH-1:0] i_raddr,
  input  logic             i_we,
  input  logic [DEPTH-1:0] i_waddr,
  input  logic [0:3]       i_be,
  input  logic [0:31]      i_wdata,
  output logic [0:31]      o_rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_bank [2**DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_we && i_be[g]) begin
        r_bank[i_waddr] <= i_wdata[8*g +: 8];
      end
      if (i_re) begin
        r_q <= r_bank[i_raddr];
      end
    end
  end

  assign o_rdata = {g_lane[0].r_q, g_lane[1].r_q, g_lane[2].r_q, g_lane[3].r_q};

endmodule

// File: rtl/dm_responder.sv
// dm_responder: memory-side responder for the pipeline data-memory port.
// One load/store at a time over req/ack, WAIT_CYCLES wait states, then a
// one-cycle ack. Stores commit enabled lanes at the end of the ack cycle;
// loads present the full word in the ack cycle, held until the next ack.
// Bit numbering is big-endian (bit 0 = MSB, lane 0 = bits 0:7).
//   clk    rising-edge clock
//   rst    synchronous active-high reset (aborts any transaction)
//   req    request valid, sampled only in IDLE
//   we     1 = store, 0 = load
//   addr   byte address; word index addr[30-DM_DEPTH:29]
//   be     lane write enables
//   wdata  lane-aligned store data
//   rdata  load word
//   ack    one-cycle completion pulse
//   busy   accept+1 through the ack cycle
//   err    alignment fault with ack
// Optional feature: define DM_ALIGN_CHK_EN to check be against addr[30:31];
// without it err is 0 and addr[30:31] is ignored.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int unsigned DM_DEPTH    = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [0:31] addr,
  input  logic [0:3]  be,
  input  logic [0:31] wdata,
  output logic [0:31] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_accept;
  logic                w_re;
  logic [DM_DEPTH-1:0] w_idx_in;
  logic [DM_DEPTH-1:0] w_raddr;
  logic [DM_DEPTH-1:0] r_idx;
  logic                r_we;
  logic [0:3]          r_be;
  logic [0:31]         r_wdata;
  logic [0:31]         r_rdata_hold;
  logic [0:31]         w_ram_q;
  logic [0:31]         w_rdata;
  logic                w_ram_we;
  logic                w_fault;

  assign w_idx_in = addr[30-DM_DEPTH:29];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; the array read is issued on the edge into RESP so the word
  // is available in the ack cycle. With no wait states that edge is the
  // accept edge, so the read must use the incoming address.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_re        = 1'b0;
    w_raddr     = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
            w_re        = 1'b1;
            w_raddr     = w_idx_in;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
          w_re        = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request latch and held read word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_idx        <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_rdata_hold <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= we;
        r_idx   <= w_idx_in;
        r_be    <= be;
        r_wdata <= wdata;
      end
      if (r_state == ST_RESP) begin
        r_rdata_hold <= w_rdata;
      end
    end
  end

`ifdef DM_ALIGN_CHK_EN
  logic r_err;
  logic w_unused_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= !be_legal(be, addr[30:31]);
    end
  end

  assign w_fault       = r_err;
  assign w_unused_addr = ^addr[0:29-DM_DEPTH];
`else
  logic w_unused_addr;

  assign w_fault       = 1'b0;
  assign w_unused_addr = ^{addr[0:29-DM_DEPTH], addr[30:31]};
`endif

  assign w_ram_we = (r_state == ST_RESP) && r_we && !w_fault;

  dm_resp_ram #(
    .DEPTH(DM_DEPTH)
  ) u_ram (
    .clk    (clk),
    .i_re   (w_re),
    .i_raddr(w_raddr),
    .i_we   (w_ram_we),
    .i_waddr(r_idx),
    .i_be   (r_be),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_q)
  );

  // In RESP: a fault forces 0, a load shows the array word, a store leaves
  // the previous word. Outside RESP the held word is shown.
  always_comb begin
    w_rdata = r_rdata_hold;
    if (r_state == ST_RESP) begin
      if (w_fault) begin
        w_rdata = '0;
      end else if (!r_we) begin
        w_rdata = w_ram_q;
      end
    end
  end

  assign rdata = w_rdata;
  assign ack   = (r_state == ST_RESP);
  assign busy  = (r_state != ST_IDLE);
  assign err   = (r_state == ST_RESP) && w_fault;

endmodule
